// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the minesweeper board logic.
package minesweeper_pkg;

    localparam int BOARD_W = 8;
    localparam int BOARD_H = 8;
    localparam int X_W     = $clog2(BOARD_W);
    localparam int Y_W     = $clog2(BOARD_H);

    localparam logic [1:0] CMD_NOP    = 2'd0;
    localparam logic [1:0] CMD_REVEAL = 2'd1;
    localparam logic [1:0] CMD_FLAG   = 2'd2;
    localparam logic [1:0] CMD_CHORD  = 2'd3;

    localparam logic [1:0] RSP_ISSUED   = 2'd0;
    localparam logic [1:0] RSP_DROP_END = 2'd1;
    localparam logic [1:0] RSP_DROP_NOP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DROP   = 2'd2,
        ST_SETTLE = 2'd3
    } sched_state_e;

    // Response code for a command at accept time; a finished game wins over a NOP.
    function automatic logic [1:0] accept_code(input logic game_ended, input logic [1:0] cmd);
        if (game_ended) begin
            return RSP_DROP_END;
        end else if (cmd == CMD_NOP) begin
            return RSP_DROP_NOP;
        end else begin
            return RSP_ISSUED;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser on each accept.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    logic rr;

    // A lone requester always wins; on contention the pointer picks the winner.
    assign gnt0 = req0 & (~req1 | ~rr);
    assign gnt1 = req1 & (~req0 | rr);

    // Pointer update: after an accept, favour the requester that was not granted.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (advance) begin
            rr <= gnt0;
        end
    end

endmodule

// File: rtl/minesweeper_cmd_sched.sv
// Command scheduler: arbitrates host/panel commands, issues them to the core,
// drops commands after game end or NOPs, and waits out the flood-fill settle time.
module minesweeper_cmd_sched
    import minesweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 80,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_valid,
    output logic             h_ready,
    input  logic [1:0]       h_cmd,
    input  logic [X_W-1:0]   h_x,
    input  logic [Y_W-1:0]   h_y,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [1:0]       p_cmd,
    input  logic [X_W-1:0]   p_x,
    input  logic [Y_W-1:0]   p_y,
    output logic             core_cmd_valid,
    output logic [1:0]       core_cmd,
    output logic [X_W-1:0]   core_x,
    output logic [Y_W-1:0]   core_y,
    input  logic             core_game_over,
    input  logic             core_win,
    output logic             rsp_valid,
    output logic             rsp_src,
    output logic [1:0]       rsp_code,
    output logic             busy,
    output logic [CNT_W-1:0] move_count
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

    sched_state_e        state_q;
    sched_state_e        state_d;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                gnt_h;
    logic                gnt_p;
    logic                accept;
    logic [1:0]          sel_cmd;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [1:0]          acc_code;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (h_valid),
        .req1    (p_valid),
        .advance (accept),
        .gnt0    (gnt_h),
        .gnt1    (gnt_p)
    );

    // Ready is only offered while idle, so at most one side handshakes per cycle.
    assign h_ready  = (state_q == ST_IDLE) & gnt_h;
    assign p_ready  = (state_q == ST_IDLE) & gnt_p;
    assign accept   = (h_valid & h_ready) | (p_valid & p_ready);
    assign sel_cmd  = gnt_p ? p_cmd : h_cmd;
    assign sel_x    = gnt_p ? p_x   : h_x;
    assign sel_y    = gnt_p ? p_y   : h_y;
    assign acc_code = accept_code(core_game_over | core_win, sel_cmd);

    // Next-state logic for the scheduler FSM.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (acc_code == RSP_ISSUED) ? ST_ISSUE : ST_DROP;
                end
            end
            ST_ISSUE:  state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
            ST_DROP:   state_d = ST_IDLE;
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register plus the registered pulse outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            busy           <= 1'b0;
            core_cmd_valid <= 1'b0;
            rsp_valid      <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy           <= (state_d != ST_IDLE);
            core_cmd_valid <= (state_d == ST_ISSUE);
            rsp_valid      <= (state_d == ST_ISSUE) | (state_d == ST_DROP);
        end
    end

    // Holding registers: response source/code on every accept, core fields only when issuing.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_src  <= 1'b0;
            rsp_code <= RSP_ISSUED;
            core_cmd <= CMD_NOP;
            core_x   <= '0;
            core_y   <= '0;
        end else if (accept) begin
            rsp_src  <= gnt_p;
            rsp_code <= acc_code;
            if (acc_code == RSP_ISSUED) begin
                core_cmd <= sel_cmd;
                core_x   <= sel_x;
                core_y   <= sel_y;
            end
        end
    end

    // Settle window: loaded as the command issues, counted down to zero while settling.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state_q == ST_ISSUE) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state_q == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // Issued-move counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            move_count <= '0;
        end else if ((state_q == ST_ISSUE) && (move_count != '1)) begin
            move_count <= move_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_minesweeper_cmd_sched.sv
// Self-checking bench: one scheduler with a 4-cycle settle window and a
// scoreboard of expected responses, plus a zero-settle, 2-bit-counter instance.
`timescale 1ns/1ps
module tb_minesweeper_cmd_sched;
    import minesweeper_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance signals (SETTLE_CYCLES=4, CNT_W=16)
    logic        h_valid, h_ready, p_valid, p_ready;
    logic [1:0]  h_cmd, p_cmd;
    logic [2:0]  h_x, h_y, p_x, p_y;
    logic        core_cmd_valid;
    logic [1:0]  core_cmd;
    logic [2:0]  core_x, core_y;
    logic        core_game_over, core_win;
    logic        rsp_valid, rsp_src, busy;
    logic [1:0]  rsp_code;
    logic [15:0] move_count;

    // Second instance signals (SETTLE_CYCLES=0, CNT_W=2)
    logic        b_h_valid, b_h_ready, b_p_valid, b_p_ready;
    logic [1:0]  b_h_cmd, b_p_cmd;
    logic [2:0]  b_h_x, b_h_y, b_p_x, b_p_y;
    logic        b_core_cmd_valid;
    logic [1:0]  b_core_cmd;
    logic [2:0]  b_core_x, b_core_y;
    logic        b_core_game_over, b_core_win;
    logic        b_rsp_valid, b_rsp_src, b_busy;
    logic [1:0]  b_rsp_code;
    logic [1:0]  b_move_count;

    minesweeper_cmd_sched #(.SETTLE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .h_valid(h_valid), .h_ready(h_ready), .h_cmd(h_cmd), .h_x(h_x), .h_y(h_y),
        .p_valid(p_valid), .p_ready(p_ready), .p_cmd(p_cmd), .p_x(p_x), .p_y(p_y),
        .core_cmd_valid(core_cmd_valid), .core_cmd(core_cmd), .core_x(core_x), .core_y(core_y),
        .core_game_over(core_game_over), .core_win(core_win),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_code(rsp_code),
        .busy(busy), .move_count(move_count)
    );

    minesweeper_cmd_sched #(.SETTLE_CYCLES(0), .CNT_W(2)) dut_fast (
        .clk(clk), .reset(reset),
        .h_valid(b_h_valid), .h_ready(b_h_ready), .h_cmd(b_h_cmd), .h_x(b_h_x), .h_y(b_h_y),
        .p_valid(b_p_valid), .p_ready(b_p_ready), .p_cmd(b_p_cmd), .p_x(b_p_x), .p_y(b_p_y),
        .core_cmd_valid(b_core_cmd_valid), .core_cmd(b_core_cmd), .core_x(b_core_x), .core_y(b_core_y),
        .core_game_over(b_core_game_over), .core_win(b_core_win),
        .rsp_valid(b_rsp_valid), .rsp_src(b_rsp_src), .rsp_code(b_rsp_code),
        .busy(b_busy), .move_count(b_move_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       src;
        logic [1:0] code;
        logic [1:0] cmd;
        logic [2:0] x;
        logic [2:0] y;
        longint     due;
    } exp_t;

    exp_t sb_q[$];
    logic model_rr;

    // Expected response for a command seen accepted at this negedge.
    function automatic void push(input logic src, input logic [1:0] cmd,
                                 input logic [2:0] x, input logic [2:0] y);
        exp_t e;
        e.src  = src;
        e.cmd  = cmd;
        e.x    = x;
        e.y    = y;
        e.due  = longint'($time) + 10;
        if (core_game_over || core_win) e.code = 2'd1;
        else if (cmd == 2'd0)            e.code = 2'd2;
        else                             e.code = 2'd0;
        sb_q.push_back(e);
    endfunction

    // Monitor: compare responses against the scoreboard, check handshake rules, record accepts.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                model_rr = 1'b0;
            end else begin
                if (h_ready && p_ready) check("both_ready", 32'(1), 32'(0));
                if ((h_ready && !h_valid) || (p_ready && !p_valid)) check("ready_no_valid", 32'(1), 32'(0));
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_time", 32'($time / 10), 32'(e.due / 10));
                        check("rsp_src", 32'(rsp_src), 32'(e.src));
                        check("rsp_code", 32'(rsp_code), 32'(e.code));
                        check("core_valid", 32'(core_cmd_valid), 32'(e.code == 2'd0));
                        if (e.code == 2'd0) begin
                            check("core_fields", 32'({core_cmd, core_x, core_y}), 32'({e.cmd, e.x, e.y}));
                        end
                    end
                end else begin
                    if (core_cmd_valid) check("stray_core_valid", 32'(1), 32'(0));
                    if (sb_q.size() > 0 && sb_q[0].due <= longint'($time)) begin
                        check("rsp_missing", 32'(0), 32'(1));
                        void'(sb_q.pop_front());
                    end
                end
                if (h_valid && p_valid && (h_ready || p_ready)) check("rr_grant", 32'(p_ready), 32'(model_rr));
                if (h_valid && h_ready) push(1'b0, h_cmd, h_x, h_y);
                if (p_valid && p_ready) push(1'b1, p_cmd, p_x, p_y);
                if (h_valid && h_ready)      model_rr = 1'b1;
                else if (p_valid && p_ready) model_rr = 1'b0;
            end
        end
    end

    // Present one command on the chosen requester and hold it until accepted.
    task automatic send(input logic src, input logic [1:0] cmd, input logic [2:0] x,
                        input logic [2:0] y, output longint t_acc);
        int n;
        @(posedge clk); #1;
        if (src) begin
            p_cmd = cmd; p_x = x; p_y = y; p_valid = 1'b1;
        end else begin
            h_cmd = cmd; h_x = x; h_y = y; h_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(src ? p_ready : h_ready) && n < 200);
        check("accept_seen", 32'(src ? p_ready : h_ready), 32'(1));
        t_acc = longint'($time);
        @(posedge clk); #1;
        h_valid = 1'b0;
        p_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        longint t0, t1, t_last;
        int     n, n_acc, k;
        logic   got_src [4];

        reset = 1'b1;
        h_valid = 0; h_cmd = 0; h_x = 0; h_y = 0;
        p_valid = 0; p_cmd = 0; p_x = 0; p_y = 0;
        core_game_over = 0; core_win = 0;
        b_h_valid = 0; b_h_cmd = 0; b_h_x = 0; b_h_y = 0;
        b_p_valid = 0; b_p_cmd = 0; b_p_x = 0; b_p_y = 0;
        b_core_game_over = 0; b_core_win = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_move_count", 32'(move_count), 32'(0));
        check("rst_core", 32'({core_cmd_valid, core_cmd, core_x, core_y}), 32'(0));
        check("rst_rsp", 32'({rsp_valid, rsp_src, rsp_code}), 32'(0));
        check("rst_ready", 32'({h_ready, p_ready}), 32'(0));

        // Host reveal (1,3,4); a second host command waits out the settle window
        send(1'b0, CMD_REVEAL, 3'd3, 3'd4, t0);
        h_cmd = CMD_FLAG; h_x = 3'd1; h_y = 3'd1; h_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("settle_busy_n%0d", i), 32'(busy), 32'(1));
            check($sformatf("settle_ready_n%0d", i), 32'(h_ready), 32'(0));
        end
        @(negedge clk);
        check("reaccept_ready", 32'(h_ready), 32'(1));
        check("reaccept_gap", 32'((longint'($time) - t0) / 10), 32'(6));
        check("idle_busy", 32'(busy), 32'(0));
        check("move_count_1", 32'(move_count), 32'(1));
        @(posedge clk); #1 h_valid = 1'b0;
        wait_idle();
        check("move_count_2", 32'(move_count), 32'(2));

        // Reset in the middle of a settle window
        send(1'b0, CMD_CHORD, 3'd7, 3'd7, t1);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_move_count", 32'(move_count), 32'(0));
        check("midrst_core", 32'({core_cmd_valid, core_cmd, core_x, core_y}), 32'(0));
        check("midrst_rsp", 32'({rsp_valid, rsp_src, rsp_code}), 32'(0));
        @(negedge clk);
        check("midrst_busy_next", 32'(busy), 32'(0));
        check("midrst_pulses_next", 32'({core_cmd_valid, rsp_valid}), 32'(0));

        // Both requesters valid: grants alternate starting from the host
        h_cmd = CMD_REVEAL; h_x = 3'd1; h_y = 3'd2;
        p_cmd = CMD_FLAG;   p_x = 3'd5; p_y = 3'd6;
        @(posedge clk); #1 h_valid = 1'b1; p_valid = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (h_ready) begin
                got_src[k] = 1'b0; k++;
            end else if (p_ready) begin
                got_src[k] = 1'b1; k++;
            end
        end
        @(posedge clk); #1 h_valid = 1'b0; p_valid = 1'b0;
        check("alt_accepts", 32'(k), 32'(4));
        for (int i = 0; i < k; i++) begin
            check($sformatf("alt_src%0d", i), 32'(got_src[i]), 32'(i % 2));
        end
        wait_idle();
        check("move_count_4", 32'(move_count), 32'(4));

        // Win at accept of a flag: dropped with code 1, back to idle two cycles later
        core_win = 1'b1;
        send(1'b0, CMD_FLAG, 3'd0, 3'd0, t1);
        core_win = 1'b0;
        @(negedge clk);
        check("win_drop_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("win_drop_idle", 32'(busy), 32'(0));
        check("win_move_count", 32'(move_count), 32'(4));

        // Panel NOP: code 2; NOP after game over: code 1
        send(1'b1, CMD_NOP, 3'd2, 3'd2, t1);
        wait_idle();
        core_game_over = 1'b1;
        send(1'b1, CMD_NOP, 3'd2, 3'd2, t1);
        core_game_over = 1'b0;
        wait_idle();
        check("nop_move_count", 32'(move_count), 32'(4));
        send(1'b1, CMD_REVEAL, 3'd6, 3'd1, t1);
        wait_idle();
        check("panel_move_count", 32'(move_count), 32'(5));

        // Zero-settle instance: back-to-back accepts every 2 cycles, counter saturates at 3
        b_h_cmd = CMD_REVEAL; b_h_x = 3'd2; b_h_y = 3'd5;
        @(posedge clk); #1 b_h_valid = 1'b1;
        n_acc = 0;
        n = 0;
        t_last = 0;
        while (n_acc < 5 && n < 50) begin
            @(negedge clk);
            n++;
            if (b_h_ready) begin
                if (n_acc > 0) check("fast_gap", 32'((longint'($time) - t_last) / 10), 32'(2));
                t_last = longint'($time);
                n_acc++;
            end
        end
        check("fast_accepts", 32'(n_acc), 32'(5));
        @(posedge clk); #1 b_h_valid = 1'b0;
        @(negedge clk);
        check("fast_core_valid", 32'(b_core_cmd_valid), 32'(1));
        check("fast_rsp", 32'({b_rsp_valid, b_rsp_code}), 32'({1'b1, 2'd0}));
        check("fast_core_fields", 32'({b_core_cmd, b_core_x, b_core_y}), 32'({2'd1, 3'd2, 3'd5}));
        @(negedge clk);
        check("fast_idle", 32'(b_busy), 32'(0));
        check("fast_move_sat", 32'(b_move_count), 32'(3));

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minesweeper_cmd_sched.md
# minesweeper_cmd_sched

Command scheduler in front of `minesweeper_core`. It arbitrates board commands from two requesters: the host (Python/PyVerilator) and the front-panel cursor/button logic. Each accepted command is issued to the core as a single `cmd_valid` pulse, followed by a fixed settle window so the core's flood-fill BFS can finish. Commands arriving after the game has ended, and NOP commands, are dropped. Every accepted command gets one response pulse.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 80: idle cycles after each issued command; covers the worst-case 64-cell flood-fill plus margin. 0 is legal.
- `CNT_W`, default 16: width of `move_count`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `h_valid` in 1 / `h_ready` out 1 / `h_cmd` in 2 / `h_x` in 3 / `h_y` in 3: host requester, valid/ready.
- `p_valid` in 1 / `p_ready` out 1 / `p_cmd` in 2 / `p_x` in 3 / `p_y` in 3: panel requester, valid/ready.
- `core_cmd_valid` out 1 / `core_cmd` out 2 / `core_x` out 3 / `core_y` out 3: to core command port.
- `core_game_over` in 1, `core_win` in 1: from core.
- `rsp_valid` out 1: one-cycle pulse, one per accepted command.
- `rsp_src` out 1: 0 = host, 1 = panel.
- `rsp_code` out 2: 0 = issued, 1 = dropped (game ended), 2 = dropped (NOP cmd 0).
- `busy` out 1: high whenever state ≠ IDLE.
- `move_count` out CNT_W: count of issued commands.

## Operation
- FSM states: IDLE, ISSUE, DROP, SETTLE.
- IDLE, grant rules:
  - Only one requester valid: grant it.
  - Both valid: grant the requester named by the round-robin pointer `rr`. `rr` = 0 (host) after reset.
  - `X_ready` = (state==IDLE) & granted X. Ready is combinational from the valids; at most one ready per cycle; never both.
- Accept = `X_valid & X_ready`. On accept:
  - Capture cmd, x, y, src into holding registers.
  - Set `rr` to the non-granted requester.
  - Evaluate the drop condition: if `core_game_over | core_win` → DROP, code 1. Else if cmd==0 → DROP, code 2. Else → ISSUE. Game-ended takes precedence over NOP.
- ISSUE (1 cycle):
  - `core_cmd_valid`=1 with the held cmd/x/y.
  - `rsp_valid`=1, code 0.
  - `move_count` +1, saturating at all-ones.
  - Next state is SETTLE, loading the counter with SETTLE_CYCLES-1. If SETTLE_CYCLES==0, next state is IDLE.
- SETTLE: decrement the counter. When it reaches 0, go to IDLE next cycle. Requests are not accepted.
- DROP (1 cycle): `rsp_valid`=1 with the stored code. No core pulse. Next state IDLE.
- `core_cmd`/`core_x`/`core_y` hold the last issued values; they are 0 after reset. They are meaningful only when `core_cmd_valid`=1.
- `core_game_over`/`core_win` are sampled only at accept. A game end during SETTLE does not affect the command already issued.
- Reset (any state, including mid-SETTLE): the next cycle is IDLE.
  - All outputs 0: `core_cmd_valid`, `core_cmd`, `core_x`, `core_y`, `rsp_valid`, `rsp_src`, `rsp_code`, `busy`, `move_count`.
  - `rr`=0. No pending pulse survives.

## Timing
- Accept in cycle N → `core_cmd_valid` and `rsp_valid` in N+1 → SETTLE in N+2 … N+1+SETTLE_CYCLES → IDLE in N+2+SETTLE_CYCLES. The next accept is possible in that IDLE cycle.
- SETTLE_CYCLES=0: IDLE in N+2, giving a throughput of one command per 2 cycles.
- Drop: `rsp_valid` in N+1, IDLE in N+2.
- All outputs are registered except `h_ready`/`p_ready`.
- Counter width is $clog2(SETTLE_CYCLES+1), minimum 1.

## Structure
- Shared package `minesweeper_pkg`:
  - CMD_NOP=0, CMD_REVEAL=1, CMD_FLAG=2, CMD_CHORD=3.
  - RSP_ISSUED=0, RSP_DROP_END=1, RSP_DROP_NOP=2.
  - FSM state encoding.
  - BOARD_W/BOARD_H constants.
- Sub-module `rr_arbiter2`: 2-input round-robin grant with an `advance` strobe. `advance` is pulsed on accept.
- Top module holds the FSM, holding registers, settle counter and move counter.

## Test plan
1. Reset; host sends reveal (1, x=3, y=4) at cycle N with SETTLE_CYCLES=4 → `core_cmd_valid`=1 only in N+1 with cmd 1/3/4; `rsp_valid` code 0 src 0 in N+1; `busy` high through N+5; `h_ready` high again at N+6; `move_count`=1.
2. Both requesters valid continuously → grants alternate host, panel, host, panel; `rsp_src` sequence 0,1,0,1; never both ready in one cycle.
3. `core_win`=1 at accept of a flag (2, 0, 0) → no `core_cmd_valid`; `rsp_code`=1 in N+1; IDLE at N+2; `move_count` unchanged.
4. Panel sends cmd 0 → `rsp_code`=2, no core pulse. Same with `core_game_over`=1 → `rsp_code`=1.
5. Assert `reset` for one cycle mid-SETTLE → next cycle IDLE, `busy`=0, `move_count`=0, `rr`=0, no stray `core_cmd_valid`/`rsp_valid`.
6. CNT_W=2, issue 5 commands → `move_count` saturates at 3; SETTLE_CYCLES=0 → accept-to-accept spacing exactly 2 cycles.
